// File: rtl/cpu_pkg.sv
// Types and constants shared by program_loader, the instruction RAM and memory_control.
package cpu_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;

  localparam logic RAM_READ  = 1'b1;
  localparam logic RAM_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CHK,
    DONE
  } loader_state_t;
endpackage

// File: rtl/program_loader_byte_packer.sv
// Collects stream bytes MSB-first into a 32-bit word; word_ready marks the 4th byte.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_ready
);
  logic [23:0] held;
  logic [1:0]  byte_cnt;

  // Only three bytes are stored; the 4th is merged combinationally so the
  // owner can register the full word on the same edge that accepts it.
  assign word_next  = {held, byte_in};
  assign word_ready = shift_en && (byte_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      held     <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (shift_en) begin
      held     <= word_next[23:0];
      byte_cnt <= byte_cnt + 2'd1;
    end
  end
endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed byte image into instruction RAM and holds the CPU until done.
// Optional trailing XOR checksum byte: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 256
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              Enable,
  output logic              RW,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] In,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold,
  output logic [15:0]       word_count
);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [16:0]       MAX_CNT = 17'(MAX_WORDS);

  loader_state_t state;
  logic [7:0]    count_hi;
  logic [15:0]   idx;
  logic          xfer;
  logic [31:0]   pk_word;
  logic          pk_word_ready;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  assign xfer = byte_valid && byte_ready;

  byte_packer u_packer (
    .clk        (Clk),
    .reset      (Reset),
    .clear      (state != DATA),
    .shift_en   (xfer && (state == DATA)),
    .byte_in    (byte_data),
    .word_next  (pk_word),
    .word_ready (pk_word_ready)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      Enable     <= 1'b0;
      RW         <= RAM_READ;
      Address    <= '0;
      In         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_hold   <= 1'b1;
      word_count <= '0;
      count_hi   <= '0;
      idx        <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LEN_HI;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
          end
        end
        LEN_HI: begin
          if (xfer) begin
            count_hi <= byte_data;
            state    <= LEN_LO;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum     <= csum ^ byte_data;
`endif
          end
        end
        LEN_LO: begin
          if (xfer) begin
            word_count <= {count_hi, byte_data};
            idx        <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum       <= csum ^ byte_data;
`endif
            if ({count_hi, byte_data} == 16'd0) begin
              state      <= DONE;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              cpu_hold   <= 1'b0;
            end else if ({1'b0, count_hi, byte_data} > MAX_CNT) begin
              state      <= DONE;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              error      <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum <= csum ^ byte_data;
`endif
            if (pk_word_ready) begin
              state      <= WRITE;
              byte_ready <= 1'b0;
              Enable     <= 1'b1;
              RW         <= RAM_WRITE;
              Address    <= BASE + ADDR_W'(idx);
              In         <= DATA_W'(pk_word);
            end
          end
        end
        WRITE: begin
          Enable <= 1'b0;
          RW     <= RAM_READ;
          idx    <= idx + 16'd1;
          if (idx + 16'd1 == word_count) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state      <= CHK;
            byte_ready <= 1'b1;
`else
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            cpu_hold   <= 1'b0;
`endif
          end else begin
            state      <= DATA;
            byte_ready <= 1'b1;
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            state      <= DONE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            error      <= (byte_data != csum);
            cpu_hold   <= (byte_data != csum);
          end
        end
`endif
        default: begin
          state      <= IDLE;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected writes/status, a monitor pops them.
module tb_program_loader;
  localparam int MAX = 256;

  logic        Clk = 1'b0;
  logic        Reset, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, Enable, RW, busy, done, error, cpu_hold;
  logic [15:0] Address;
  logic [31:0] In;
  logic [15:0] word_count;

  program_loader #(.ADDR_W(16), .DATA_W(32), .BASE_ADDR(0), .MAX_WORDS(MAX)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .Enable(Enable), .RW(RW), .Address(Address), .In(In),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold), .word_count(word_count)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [15:0] a; logic [31:0] d; } wr_t;
  typedef struct { bit err; logic [15:0] wc; } st_t;
  wr_t wq[$];
  st_t sq[$];
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every RAM strobe and every completed load against the queues.
  initial begin
    logic dprev;
    wr_t  w;
    st_t  s;
    dprev = 1'b0;
    forever begin
      @(negedge Clk);
      if (Reset !== 1'b1) begin
        if (Enable) begin
          if (wq.size() == 0) chk("unexpected_write", {Address, In}, 64'hDEAD);
          else begin
            w = wq.pop_front();
            chk("write_rw", RW, 0);
            chk("write_addr", Address, w.a);
            chk("write_data", In, w.d);
          end
        end
        if (done && !dprev) begin
          if (sq.size() == 0) chk("unexpected_done", done, 0);
          else begin
            s = sq.pop_front();
            chk("done_error", error, s.err);
            chk("done_hold", cpu_hold, s.err);
            chk("done_wcount", word_count, s.wc);
            chk("done_busy", busy, 0);
          end
        end
      end
      dprev = done;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  // gap_mode: 0 = back-to-back, 1 = two idle cycles, 2 = random 0..2 idle cycles
  task automatic send_byte(input logic [7:0] b, input int gap_mode);
    int gap;
    int guard;
    gap = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
    byte_valid = 1'b0;
    repeat (gap) @(negedge Clk);
    byte_valid = 1'b1;
    byte_data  = b;
    guard = 0;
    while (!byte_ready && guard < 100) begin
      @(negedge Clk);
      guard++;
    end
    if (!byte_ready) chk("byte_ready_timeout", byte_ready, 1);
    @(negedge Clk);
    byte_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_byte_ready"}, byte_ready, 0);
    chk({tag, "_enable"}, Enable, 0);
    chk({tag, "_rw"}, RW, 1);
    chk({tag, "_address"}, Address, 0);
    chk({tag, "_in"}, In, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 1);
    chk({tag, "_word_count"}, word_count, 0);
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (!done && g < 50) begin
      @(negedge Clk);
      g++;
    end
    if (!done) chk("done_timeout", done, 1);
    @(negedge Clk);
  endtask

  task automatic run_load(input int cnt, input logic [31:0] words[$], input int gap_mode,
                          input bit corrupt, input bit start_mid);
    logic [7:0]  s[$];
    logic [15:0] c16;
    logic [7:0]  x;
    bit          err;
    int          nw;
    wr_t         w;
    st_t         st;
    c16 = cnt[15:0];
    s.push_back(c16[15:8]);
    s.push_back(c16[7:0]);
    err = (cnt > MAX);
    nw  = (cnt > 0 && !err) ? cnt : 0;
    for (int i = 0; i < nw; i++)
      for (int k = 3; k >= 0; k--) s.push_back(8'(words[i] >> (8 * k)));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (nw > 0) begin
      x = '0;
      foreach (s[k]) x ^= s[k];
      if (corrupt) x ^= 8'h5A;
      s.push_back(x);
      err = corrupt;
    end
`else
    x = 8'(corrupt);
`endif
    pulse_start();
    chk("started_busy", busy, 1);
    chk("started_hold", cpu_hold, 1);
    chk("started_done", done, 0);
    for (int i = 0; i < s.size(); i++) begin
      if (i == s.size() - 1) begin
        st.err = err;
        st.wc  = c16;
        sq.push_back(st);
      end
      if (i >= 2 && i < 2 + 4 * nw && ((i - 2) % 4) == 3) begin
        w.a = 16'((i - 2) / 4);
        w.d = words[(i - 2) / 4];
        wq.push_back(w);
      end
      if (start_mid && i == 4) pulse_start();
      send_byte(s[i], gap_mode);
    end
    wait_done();
  endtask

  initial begin
    logic [31:0] img[$];
    logic [31:0] none[$];
    int          n;
    Reset = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = '0;
    repeat (3) @(negedge Clk);
    check_reset_values("reset");
    Reset = 1'b0;

    // Bytes offered while idle must be ignored.
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    repeat (3) @(negedge Clk);
    chk("idle_ready", byte_ready, 0);
    chk("idle_busy", busy, 0);
    byte_valid = 1'b0;

    img = '{32'hE1234567, 32'h0000000A};
    run_load(2, img, 0, 1'b0, 1'b0);
    chk("basic_done", done, 1);
    chk("basic_hold", cpu_hold, 0);
    run_load(2, img, 1, 1'b0, 1'b0);
    run_load(0, none, 0, 1'b0, 1'b0);
    run_load(257, none, 0, 1'b0, 1'b0);
    chk("oversize_hold", cpu_hold, 1);

    // Bytes offered in DONE are ignored too.
    byte_valid = 1'b1;
    repeat (3) @(negedge Clk);
    chk("done_ready", byte_ready, 0);
    byte_valid = 1'b0;

    // Reset after two data bytes of word 1.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    Reset = 1'b1;
    @(negedge Clk);
    check_reset_values("midreset");
    Reset = 1'b0;
    run_load(2, img, 0, 1'b0, 1'b0);

    run_load(2, img, 2, 1'b0, 1'b1);

    for (int t = 0; t < 8; t++) begin
      n = int'($urandom_range(1, 6));
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
      run_load(n, img, int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end
    img.delete();
    for (int i = 0; i < MAX; i++) img.push_back($urandom);
    run_load(MAX, img, 0, 1'b0, 1'b0);
    run_load(int'($urandom_range(MAX + 1, 65535)), none, 0, 1'b0, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    img = '{32'hE1234567, 32'h0000000A};
    run_load(2, img, 0, 1'b1, 1'b0);
    chk("bad_csum_hold", cpu_hold, 1);
    run_load(2, img, 2, 1'b0, 1'b0);
    chk("good_csum_hold", cpu_hold, 0);
`endif

    repeat (5) @(negedge Clk);
    chk("writes_left", wq.size(), 0);
    chk("status_left", sq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer-side counterpart of the CPU instruction fetch path. The fetch path only reads instruction words from RAM; this block writes them.
- Receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them into the instruction RAM through its Enable/RW/Address/In port.
- Holds the CPU off (cpu_hold) until the image is fully written.
- Replaces simulation-only preloading of RAM contents.

Parameters:
- ADDR_W, 16, RAM address width
- DATA_W, 32, RAM word width (fixed 4 bytes per word)
- BASE_ADDR, 0, RAM address of the first loaded word
- MAX_WORDS, 256, largest accepted word count

Ports:
- Clk  in  1  system clock, all logic on posedge
- Reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that begins a load
- byte_valid  in  1  byte_data holds a valid byte
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- Enable  out  1  RAM enable
- RW  out  1  RAM direction: 1 = read, 0 = write
- Address  out  ADDR_W  RAM address
- In  out  DATA_W  RAM write data
- busy  out  1  load in progress
- done  out  1  image loaded, level signal
- error  out  1  load aborted (count too large / checksum)
- cpu_hold  out  1  1 keeps the CPU fetch stalled
- word_count  out  16  word count of the last header received

Behaviour:
- Reset values: byte_ready=0, Enable=0, RW=1, Address=0, In=0, busy=0, done=0, error=0, cpu_hold=1, word_count=0, state=IDLE.
- All outputs are registered.
- Byte transfer occurs only on a cycle where byte_valid && byte_ready.
- byte_ready=1 only in LEN_HI, LEN_LO, DATA and CHK.
- Stream format: count[15:8], count[7:0], then count×4 data bytes, MSB first per word; CHK byte only with the optional feature.
- States:
  - IDLE: wait for start. start -> LEN_HI; busy=1, cpu_hold=1, done=0, error=0.
  - LEN_HI: capture the high count byte -> LEN_LO.
  - LEN_LO: capture the low count byte; word_count updated.
    - count==0 -> DONE with no writes.
    - count>MAX_WORDS -> DONE with error=1.
    - otherwise -> DATA with idx=0, byte_cnt=0.
  - DATA: shift bytes into the word register. The 4th byte goes to WRITE.
  - WRITE: exactly one cycle with Enable=1, RW=0, Address=BASE_ADDR+idx (modulo 2^ADDR_W), In=assembled word.
    - Then idx+1; if idx+1==count -> CHK (feature on) or DONE; else -> DATA.
    - Outside WRITE: Enable=0, RW=1.
  - DONE: busy=0, done=1. cpu_hold=0 only if error==0; on error, cpu_hold stays 1. start -> LEN_HI (restart, done cleared).
- Latency: RAM write strobe occurs in the cycle after the 4th byte is accepted. Minimum 5 cycles per word at full stream rate.
- start while busy (any state other than IDLE or DONE): ignored.
- byte_valid in IDLE or DONE: not accepted, no effect.
- Stalls: byte_valid low for any number of cycles pauses the load; no timeout.
- Reset mid-load: immediate return to reset values. RAM words already written stay; the partial word is discarded.
- Address wrap: BASE_ADDR+idx wraps modulo 2^ADDR_W; no error.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined: after the last word, state CHK accepts one byte. It must equal the XOR of all count and data bytes.
  - Mismatch -> error=1, cpu_hold stays 1.
  - Match -> normal DONE.
- Undefined: no CHK state; DONE follows the last WRITE directly. error is set only by count>MAX_WORDS.

Decomposition:
- Shared package cpu_pkg holds:
  - loader state enum (IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHK, DONE)
  - RAM_READ=1 / RAM_WRITE=0 constants
  - DATA_W and ADDR_W defaults, shared with RAM and memory_control
- One sub-module: byte_packer, a 4-byte shift register with byte counter and word_ready pulse.

Test Plan:
- Basic load: Reset, start, bytes 00 02 E1 23 45 67 00 00 00 0A -> two write cycles: Address 0 In=E1234567, then Address 1 In=0000000A; then done=1, cpu_hold=0, word_count=2.
- Throttled stream: same image with byte_valid toggling 1-0-0-1 -> identical writes and order; no extra Enable pulses.
- Zero and oversize count:
  - header 00 00 -> DONE, no Enable, error=0.
  - header 01 01 (257) -> error=1, cpu_hold=1, no writes.
- Reset mid-word: Reset asserted after 2 data bytes of word 1 -> next cycle all outputs at reset values; a fresh start loads correctly from idx 0.
- start during load: start pulsed while in DATA -> ignored; writes unchanged.
- Checksum (macro on): correct XOR byte -> done, error=0; corrupted byte -> error=1, cpu_hold=1.
